// File: rtl/pe_pkg.sv
// Shared widths and the accumulator addend select encoding for the processing element.
package pe_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FRAC_BITS  = 8;

    // Accumulator addend source.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ACC  = 2'd1,
        FIFO = 2'd2,
        HOLD = 2'd3
    } mux_sel_e;

endpackage

// File: rtl/processing_element_if.sv
// Control and data bus of one processing element: the driver side issues MAC/FIFO
// commands and operands, the PE side returns the registered neuron output.
interface processing_element_if #(
    parameter int unsigned DATA_W = pe_pkg::DATA_W
);
    logic [1:0]               mux_select;
    logic                     demux_select;
    logic                     read_enable;
    logic                     write_enable;
    logic signed [DATA_W-1:0] input_data;
    logic signed [DATA_W-1:0] weight;
    logic signed [DATA_W-1:0] pe_out;

    modport master (
        output mux_select, demux_select, read_enable, write_enable, input_data, weight,
        input  pe_out
    );

    modport slave (
        input  mux_select, demux_select, read_enable, write_enable, input_data, weight,
        output pe_out
    );
endinterface

// File: rtl/pe_psum_fifo.sv
// Partial-sum FIFO: power-of-two depth, wrapping pointers, explicit occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
// Storage is not reset; only pointers and count are.
module pe_psum_fifo #(
    parameter int unsigned WIDTH = pe_pkg::ACC_W,
    parameter int unsigned DEPTH = pe_pkg::FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_c;
    logic             pop_ok_c;
    logic             push_ok_c;

    // Status, accepted operations and next pointer/count values.
    always_comb begin
        empty_c   = (count_q == '0);
        full_c    = (count_q == CNT_W'(DEPTH));
        head_c    = mem_q[rd_ptr_q];
        pop_ok_c  = pop && !empty_c;
        push_ok_c = push && (!full_c || pop_ok_c);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/processing_element.sv
// Processing element: Q8.8 x Q8.8 MAC into a saturating Q16.16 accumulator, a
// partial-sum FIFO for spilling/restoring sums, and a ReLU output register.
// Writes (FIFO push or output load) always use the accumulator value from before
// this cycle's update.
module processing_element #(
    parameter int unsigned DATA_W     = pe_pkg::DATA_W,
    parameter int unsigned ACC_W      = pe_pkg::ACC_W,
    parameter int unsigned FIFO_DEPTH = pe_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mux_select,
    input  logic                     demux_select,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [DATA_W-1:0] pe_out
);
    import pe_pkg::*;

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] pe_out_q, pe_out_d;
    logic signed [PROD_W-1:0] product_c;
    logic signed [ACC_W-1:0]  product_ext_c;
    logic signed [ACC_W-1:0]  addend_c;
    logic signed [ACC_W:0]    sum_c;
    logic signed [ACC_W-1:0]  sum_sat_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [DATA_W-1:0] relu_c;
    logic [ACC_W-1:0]         fifo_head_c;
    logic                     fifo_empty_c;
    logic                     fifo_push_c;

    assign pe_out      = pe_out_q;
    assign fifo_push_c = write_enable && !demux_select;

    pe_psum_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push_c),
        .pop       (read_enable),
        .push_data (acc_q),
        .head_c    (fifo_head_c),
        .empty_c   (fifo_empty_c)
    );

    // MAC: pick the addend, add the full-precision product with one guard bit, clamp.
    always_comb begin
        product_c     = PROD_W'(input_data) * PROD_W'(weight);
        product_ext_c = ACC_W'(product_c);
        case (mux_sel_e'(mux_select))
            ACC:     addend_c = acc_q;
            FIFO:    addend_c = fifo_empty_c ? '0 : fifo_head_c;
            default: addend_c = '0;
        endcase
        sum_c = (ACC_W+1)'(addend_c) + (ACC_W+1)'(product_ext_c);
        if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
            sum_sat_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat_c = sum_c[ACC_W-1:0];
        end
        acc_d = (mux_sel_e'(mux_select) == HOLD) ? acc_q : sum_sat_c;
    end

    // Output path: drop fraction bits, ReLU, clamp to the positive DATA_W range.
    always_comb begin
        shifted_c = acc_q >>> FRAC_BITS;
        if (shifted_c[ACC_W-1]) begin
            relu_c = '0;
        end else if (|shifted_c[ACC_W-2:DATA_W-1]) begin
            relu_c = OUT_MAX;
        end else begin
            relu_c = shifted_c[DATA_W-1:0];
        end
        pe_out_d = pe_out_q;
        if (write_enable && demux_select) begin
            pe_out_d = relu_c;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            pe_out_q <= '0;
        end else begin
            acc_q    <= acc_d;
            pe_out_q <= pe_out_d;
        end
    end

endmodule

// File: tb/tb_processing_element.sv
// Scoreboard bench for processing_element: each output-register write pushes its
// hand-computed value; a monitor pops and compares one cycle after every strobe.
module tb_processing_element;
    import pe_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] exp_q [$];

    processing_element_if #(.DATA_W(16)) bus ();

    processing_element #(
        .DATA_W     (16),
        .ACC_W      (32),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mux_select   (bus.mux_select),
        .demux_select (bus.demux_select),
        .read_enable  (bus.read_enable),
        .write_enable (bus.write_enable),
        .input_data   (bus.input_data),
        .weight       (bus.weight),
        .pe_out       (bus.pe_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cyc(input logic [1:0] m, input logic d, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] b);
        bus.mux_select   = m;
        bus.demux_select = d;
        bus.read_enable  = r;
        bus.write_enable = w;
        bus.input_data   = a;
        bus.weight       = b;
        @(posedge clk);
        #1;
    endtask

    // Output-register write with its expected pe_out queued for the monitor.
    task automatic cyc_w(input logic [1:0] m, input logic r,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        exp_q.push_back(e);
        cyc(m, 1'b1, r, 1'b1, a, b);
    endtask

    // Monitor: every sampled output strobe makes pe_out due at the following negedge.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            if (reset && bus.write_enable && bus.demux_select) begin
                @(negedge clk);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pe_out unexpected strobe actual=%h required=none", bus.pe_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.pe_out !== e) begin
                        errors++;
                        $display("FAIL pe_out actual=%h required=%h", bus.pe_out, e);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.mux_select   = 2'd0;
        bus.demux_select = 1'b0;
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        bus.input_data   = '0;
        bus.weight       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pe_out", 32'(bus.pe_out), 32'h0);
        check("reset_acc", dut.acc_q, 32'h0);
        reset = 1'b1;

        // MAC: 1.0*2.0 + 0.5*1.0 = 2.5
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0200);
        cyc(ACC,  1'b0, 1'b0, 1'b0, 16'h0080, 16'h0100);
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h0280);

        // ReLU on -1.0
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'hFF00, 16'h0100);
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h0000);

        // Saturation: four max-positive products; each write sees the pre-update sum
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc(ACC, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 3; i++) begin
            cyc_w(ACC, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        end
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h7FFF);

        // FIFO order: push 1.0, 2.0, 3.0; pop-and-load chain, then an empty read
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100);
        cyc(ZERO, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0100);
        cyc(ZERO, 1'b0, 1'b0, 1'b1, 16'h0300, 16'h0100);
        cyc(HOLD, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'h0300);
        cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'h0100);
        cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'h0200);
        cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'h0300);
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h0000);

        // FIFO full: push 1..8, 9th dropped, then push 9 with a pop while full
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100);
        for (int i = 2; i <= 9; i++) begin
            cyc(ZERO, 1'b0, 1'b0, 1'b1, 16'(i << 8), 16'h0100);
        end
        cyc(HOLD, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        cyc(ZERO, 1'b0, 1'b1, 1'b1, 16'h0A00, 16'h0100);
        cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'h0A00);
        for (int i = 2; i <= 8; i++) begin
            cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'(i << 8));
        end
        cyc_w(FIFO, 1'b1, 16'h0, 16'h0, 16'h0900);
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h0000);

        // Peek: mux=2 without read_enable reuses the same head
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0100);
        cyc(HOLD, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        cyc(FIFO, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100);
        cyc_w(FIFO, 1'b0, 16'h0100, 16'h0100, 16'h0600);
        cyc_w(HOLD, 1'b1, 16'h0, 16'h0, 16'h0600);
        cyc_w(FIFO, 1'b0, 16'h0, 16'h0, 16'h0600);
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h0000);

        // Reset mid-accumulation with a non-empty FIFO and a non-zero pe_out
        cyc(ZERO, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0100);
        cyc(HOLD, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        cyc_w(ACC, 1'b0, 16'h0100, 16'h0100, 16'h0200);
        cyc(ACC, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pe_out", 32'(bus.pe_out), 32'h0);
        check("async_rst_acc", dut.acc_q, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(FIFO, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100);
        cyc_w(HOLD, 1'b0, 16'h0, 16'h0, 16'h0100);

        cyc(HOLD, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
